// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Optional build macro: REGFILE_BYPASS_EN (write-first read bypass).
package regfile_pkg;

    typedef enum logic {
        CLEAR,
        IDLE
    } clrState_e;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_NUM_RD = 2;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: after reset it sweeps every entry to zero, one per cycle,
// and holds busy high until the last entry has been written.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

    clrState_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              sweepWe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sweepWe = 1'b0;
        unique case (state_q)
            CLEAR: begin
                sweepWe = 1'b1;
                ptr_d   = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // A cycle that still has reset asserted does not count as a sweep step.
    assign busy     = (state_q == CLEAR);
    assign clr_we   = sweepWe & ~rst;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte strobes, hard-wired zero entry and
// a post-reset clear sweep. Define REGFILE_BYPASS_EN for write-first reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NUM_RD = REGFILE_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0]        test_addr,
    output logic [DATA_W-1:0]        test_data,
    output logic                     busy
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int NUM_BYT = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clrWe;
    logic [ADDR_W-1:0] clrAddr;
    logic              wrAccept;
    logic [DATA_W-1:0] wrWord;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) uClrSeq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clrWe),
        .clr_addr (clrAddr)
    );

    assign wrAccept = wen & ~busy & ~rst & (waddr != '0);

    always_comb begin
        wrWord = mem_q[waddr];
        for (int b = 0; b < NUM_BYT; b++) begin
            if (wstrb[b]) begin
                wrWord[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Storage is only zeroed by the sweep, never in parallel on reset.
    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem_q[clrAddr] <= '0;
        end else if (wrAccept) begin
            mem_q[waddr] <= wrWord;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRdPort
        logic [ADDR_W-1:0] portAddr;
        logic [DATA_W-1:0] portData;

        assign portAddr = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            portData = mem_q[portAddr];
`ifdef REGFILE_BYPASS_EN
            if (wrAccept && (portAddr == waddr)) begin
                portData = wrWord;
            end
`endif
            if (busy || (portAddr == '0)) begin
                portData = '0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = portData;
    end

    always_comb begin
        test_data = mem_q[test_addr];
        if (busy || (test_addr == '0)) begin
            test_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard testbench for regfile_mp: expectations are queued as stimulus is
// driven and popped against the combinational read outputs.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] exp;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             wen;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wstrb;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [AW-1:0]    test_addr;
    logic [DW-1:0]    test_data;
    logic             busy;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] model [DEPTH];
    exp_t        sbQ [$];

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .raddr     (raddr),
        .rdata     (rdata),
        .test_addr (test_addr),
        .test_data (test_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int src);
        case (src)
            0:       return rdata[31:0];
            1:       return rdata[63:32];
            2:       return test_data;
            default: return {31'd0, busy};
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    task automatic pushExp(input string tag, input int src, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sbQ.push_back(e);
    endtask

    task automatic drainScoreboard();
        exp_t e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e.tag, observe(e.src), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = s;
        tick();
        wen = 1'b0;
        if (a != 5'd0) model[a] = merge(model[a], d, s);
    endtask

    // Counts cycles until busy drops; optionally attempts a write late in the sweep.
    task automatic waitClear(input bit pokeWrite, output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (pokeWrite && n == 20) begin
                wen   = 1'b1;
                waddr = 5'd6;
                wdata = 32'hCAFEF00D;
                wstrb = 4'hF;
            end else begin
                wen = 1'b0;
            end
            tick();
            n++;
        end
        wen = 1'b0;
        foreach (model[i]) model[i] = 32'd0;
    endtask

    task automatic sweepZero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            test_addr = AW'(a);
            #1;
            pushExp(tag, 2, 32'd0);
            drainScoreboard();
        end
    endtask

    initial begin
        int n;
        logic [4:0] ra;
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
        raddr = '0; test_addr = '0;
        foreach (model[i]) model[i] = 32'd0;

        tick();
        pushExp("reset_busy", 3, 32'd1);
        pushExp("reset_test", 2, 32'd0);
        drainScoreboard();
        rst = 1'b0;
        waitClear(1'b0, n);
        checkOutput("clear_cycles", n, 32);
        sweepZero("sweep_after_clear");

        applyStimulus(5'd1, 32'hFFFFFFFF, 4'hF);
        applyStimulus(5'd2, 32'h0000FFFF, 4'hF);
        applyStimulus(5'd3, 32'hFFFF0000, 4'hF);
        raddr = {5'd2, 5'd1};
        test_addr = 5'd3;
        #1;
        pushExp("wr_port0", 0, 32'hFFFFFFFF);
        pushExp("wr_port1", 1, 32'h0000FFFF);
        pushExp("wr_test", 2, 32'hFFFF0000);
        drainScoreboard();

        applyStimulus(5'd0, 32'h12345678, 4'hF);
        raddr = {5'd0, 5'd0};
        #1;
        pushExp("addr0_port0", 0, 32'd0);
        pushExp("addr0_port1", 1, 32'd0);
        drainScoreboard();

        applyStimulus(5'd4, 32'hAABBCCDD, 4'hF);
        applyStimulus(5'd4, 32'h11223344, 4'b0101);
        raddr = {5'd4, 5'd4};
        test_addr = 5'd4;
        #1;
        pushExp("strb_port0", 0, 32'hAA22CC44);
        pushExp("strb_port1", 1, 32'hAA22CC44);
        pushExp("strb_test", 2, 32'hAA22CC44);
        drainScoreboard();

        applyStimulus(5'd4, 32'h00000000, 4'h0);
        #1;
        pushExp("strb_zero", 2, 32'hAA22CC44);
        drainScoreboard();

        raddr = {5'd0, 5'd5};
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        #1;
`ifdef REGFILE_BYPASS_EN
        pushExp("same_cycle", 0, 32'hDEADBEEF);
`else
        pushExp("same_cycle", 0, 32'h00000000);
`endif
        drainScoreboard();
        tick();
        wen = 1'b0;
        model[5] = 32'hDEADBEEF;
        #1;
        pushExp("next_cycle", 0, 32'hDEADBEEF);
        drainScoreboard();

        for (int i = 0; i < 24; i++) begin
            ra = 5'($urandom_range(0, 31));
            applyStimulus(ra, $urandom, 4'($urandom_range(0, 15)));
            raddr = {ra, 5'($urandom_range(0, 31))};
            test_addr = 5'($urandom_range(0, 31));
            #1;
            pushExp("rand_port0", 0, model[raddr[4:0]]);
            pushExp("rand_port1", 1, model[ra]);
            pushExp("rand_test", 2, model[test_addr]);
            drainScoreboard();
        end

        // Reset with a pending write; entries 1..3 still hold data while busy masks reads.
        rst = 1'b1;
        wen = 1'b1; waddr = 5'd7; wdata = 32'h77777777; wstrb = 4'hF;
        raddr = {5'd3, 5'd1};
        test_addr = 5'd2;
        tick();
        wen = 1'b0;
        rst = 1'b0;
        pushExp("rst_busy", 3, 32'd1);
        pushExp("busy_port0", 0, 32'd0);
        pushExp("busy_port1", 1, 32'd0);
        pushExp("busy_test", 2, 32'd0);
        drainScoreboard();

        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        waitClear(1'b1, n);
        checkOutput("reclear_cycles", n, 32);
        sweepZero("sweep_after_reclear");

        applyStimulus(5'd6, 32'hCAFEF00D, 4'hF);
        test_addr = 5'd6;
        #1;
        pushExp("write_after_reclear", 2, 32'hCAFEF00D);
        drainScoreboard();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..8).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 wen  in  1  write request.
REQ-008 waddr  in  ADDR_W  write address.
REQ-009 wdata  in  DATA_W  write data.
REQ-010 wstrb  in  DATA_W/8  byte write enables, bit i covers wdata[8i+7:8i].
REQ-011 raddr  in  NUM_RD*ADDR_W  packed read addresses, port k in slice k.
REQ-012 rdata  out  NUM_RD*DATA_W  packed read data, port k in slice k.
REQ-013 test_addr  in  ADDR_W  debug read address.
REQ-014 test_data  out  DATA_W  debug read data.
REQ-015 busy  out  1  high while the clear sequence runs.

Function
REQ-016 Reads SHALL be combinational: rdata port k = entry[raddr k] in the same cycle; test_data likewise for test_addr.
REQ-017 Write SHALL occur at the rising edge when wen=1, busy=0, waddr!=0; only bytes with wstrb bit set change.
REQ-018 Entry 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-019 FSM states: CLEAR, IDLE; CLEAR -> IDLE after the entry at ptr=DEPTH-1 is zeroed; IDLE -> CLEAR only via rst.
REQ-020 In CLEAR, each cycle with rst=0 SHALL write 0 to entry[ptr] and increment ptr; clear takes exactly DEPTH cycles after rst deasserts.
REQ-021 busy SHALL equal 1 in CLEAR and 0 in IDLE.
REQ-022 While busy=1, all rdata and test_data SHALL read 0 and wen SHALL be ignored (write lost, no retry).
REQ-023 Multiple read ports addressing the same entry SHALL return identical data.
REQ-024 wstrb=0 with wen=1 SHALL leave storage unchanged.

Reset
REQ-025 rst=1 SHALL force state CLEAR, ptr=0, busy=1 on the next edge; storage contents are not reset in parallel.
REQ-026 rst asserted mid-clear SHALL restart the sweep from ptr=0.
REQ-027 rst asserted while wen=1 SHALL discard that write.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: a read port whose address equals waddr while a write is accepted SHALL return the byte-merged new value in the same cycle (write-first); address 0 still reads 0.
REQ-029 Macro REGFILE_BYPASS_EN undefined: same-cycle read SHALL return the old value; new value visible from the next cycle.

Structure
REQ-030 Package regfile_pkg SHALL hold the state typedef (CLEAR, IDLE) and the default DATA_W/ADDR_W/NUM_RD constants.
REQ-031 Sub-module regfile_clr_seq SHALL contain the clear FSM and ptr counter, outputting busy, clr_we, clr_addr.
REQ-032 Read ports SHALL be generated by a generate loop over NUM_RD; no per-port hand-written logic.

Verification
REQ-033 Reset 1 cycle, then count cycles until busy=0 -> exactly 32 cycles (ADDR_W=5); all 32 entries read 0 via test_addr sweep.
REQ-034 Write addr1=FFFFFFFF, addr2=0000FFFF, addr3=FFFF0000 with wstrb=F; raddr0=1, raddr1=2, test_addr=3 next cycle -> FFFFFFFF, 0000FFFF, FFFF0000.
REQ-035 Write addr 0 = 12345678 -> rdata for raddr=0 stays 00000000.
REQ-036 Entry 4=AABBCCDD, then write 11223344 with wstrb=0101b -> entry 4 reads AA22CC44.
REQ-037 Same-cycle write addr 5=DEADBEEF with raddr0=5 -> DEADBEEF with REGFILE_BYPASS_EN, prior value (0) without; next cycle DEADBEEF in both.
REQ-038 Assert rst at clear cycle 10, release -> busy lasts 32 further cycles; write during busy to addr 6=CAFEF00D -> entry 6 reads 0 after clear.
